// File: rtl/byte_dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the byte-addressable data memory (byte_dm):
//   - req_op encoding (W, HU, HS, BU, BS)
//   - FSM state enum (CLEAR, IDLE, BUSY)
//   - access-size classification and alignment helpers
// -----------------------------------------------------------------------------
package dm_pkg;

  typedef enum logic [2:0] {
    OP_W  = 3'd0,
    OP_HU = 3'd1,
    OP_HS = 3'd2,
    OP_BU = 3'd3,
    OP_BS = 3'd4
  } dm_op_e;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } dm_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } dm_size_e;

  // Stores ignore signedness, so HU/HS collapse to half and BU/BS to byte.
  // Unknown encodings are treated as full-word accesses.
  function automatic dm_size_e opSize(input logic [2:0] op);
    dm_size_e sz;
    case (op)
      OP_HU, OP_HS: sz = SZ_HALF;
      OP_BU, OP_BS: sz = SZ_BYTE;
      default:      sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic isMisaligned(input dm_size_e sz, input logic [1:0] lane);
    logic bad;
    case (sz)
      SZ_WORD: bad = (lane != 2'b00);
      SZ_HALF: bad = lane[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_dm_if.sv
// -----------------------------------------------------------------------------
// byte_dm_if
// Request/response bundle for byte_dm.
//   Request : req_valid, req_ready, req_we, req_op[2:0], req_addr[31:0],
//             req_wdata[31:0], req_pc[31:0]
//   Response: rsp_valid, rsp_rdata[31:0], rsp_err
//   Status  : init_busy
//   Trace   : trace_valid, trace_pc, trace_addr, trace_data -- one pulse per
//             committed store, carrying the merged word, for simulation logging
// master = requester, slave = memory.
// -----------------------------------------------------------------------------
interface byte_dm_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        init_busy;

  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy,
    input  trace_valid, trace_pc, trace_addr, trace_data
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy,
    output trace_valid, trace_pc, trace_addr, trace_data
  );

endinterface

// File: rtl/dm_lane.sv
// -----------------------------------------------------------------------------
// dm_lane
// Purely combinational byte-lane logic for byte_dm.
//   old_word_i : current contents of the addressed word
//   wdata_i    : low-aligned store data
//   op_i       : access type (dm_op_e encoding)
//   lane_i     : byte lane, addr[1:0]
//   merged_o   : old word with the addressed lanes replaced by store data
//   load_o     : selected word/half/byte, zero- or sign-extended
// -----------------------------------------------------------------------------
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  // Store merge: only the addressed lanes take new data.
  always_comb begin
    merged_o = old_word_i;
    case (opSize(op_i))
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      default: merged_o = wdata_i;
    endcase
  end

  // Load extraction: half selected by lane[1], byte by the full lane.
  always_comb begin
    halfSel = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    byteSel = old_word_i[{lane_i, 3'b000} +: 8];
    case (op_i)
      OP_HU:   load_o = {16'h0000, halfSel};
      OP_HS:   load_o = {{16{halfSel[15]}}, halfSel};
      OP_BU:   load_o = {24'h000000, byteSel};
      OP_BS:   load_o = {{24{byteSel[7]}}, byteSel};
      default: load_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/byte_dm.sv
// -----------------------------------------------------------------------------
// byte_dm
// Byte-addressable data memory of DEPTH 32-bit words with a fixed response
// latency. After reset the whole array is cleared, one word per cycle.
// Parameters:
//   DEPTH     : number of 32-bit words
//   LATENCY   : edges from acceptance to response, 1..4
//   BASE_ADDR : byte address of word 0
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : byte_dm_if slave (request, response, init_busy, store trace)
// -----------------------------------------------------------------------------
module byte_dm
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH     = 3072,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
  input  logic     clk,
  input  logic     reset,
  byte_dm_if.slave bus
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dm_state_e         state_q, state_d;
  logic [IDXW-1:0]   clrIdx_q, clrIdx_d;
  logic [1:0]        latCnt_q, latCnt_d;
  logic [31:0]       pendRdata_q, pendRdata_d;
  logic              pendErr_q, pendErr_d;
  logic              rspValid_q, rspValid_d;
  logic [31:0]       rspRdata_q, rspRdata_d;
  logic              rspErr_q, rspErr_d;
  logic              traceValid_q, traceValid_d;
  logic [31:0]       tracePc_q, tracePc_d;
  logic [31:0]       traceAddr_q, traceAddr_d;
  logic [31:0]       traceData_q, traceData_d;

  logic [31:0]       mem_q [DEPTH];

  logic              borrow;
  logic [31:0]       offset;
  logic [31:0]       wordIdx;
  logic              reqErr;
  logic [IDXW-1:0]   memIdx;
  logic [31:0]       oldWord;
  logic [31:0]       mergedWord;
  logic [31:0]       loadWord;
  logic [31:0]       loadResult;
  logic              accept;

  logic              memWe;
  logic [IDXW-1:0]   memWIdx;
  logic [31:0]       memWData;

  // Address decode. The borrow out of the subtraction flags addresses below
  // BASE_ADDR without a compare that would be constant for BASE_ADDR=0.
  always_comb begin
    {borrow, offset} = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    wordIdx = offset >> 2;
    reqErr  = borrow
            | (wordIdx >= 32'(DEPTH))
            | isMisaligned(opSize(bus.req_op), bus.req_addr[1:0]);
    memIdx  = reqErr ? '0 : wordIdx[IDXW-1:0];
  end

  assign oldWord = mem_q[memIdx];

  dm_lane u_lane (
    .old_word_i (oldWord),
    .wdata_i    (bus.req_wdata),
    .op_i       (bus.req_op),
    .lane_i     (bus.req_addr[1:0]),
    .merged_o   (mergedWord),
    .load_o     (loadWord)
  );

  assign accept     = bus.req_valid && (state_q == IDLE);
  assign loadResult = (bus.req_we || reqErr) ? 32'h0 : loadWord;

  // Next-state logic. A single memory write port is shared between the
  // clear sweep and committed stores; they never overlap because stores are
  // only accepted in IDLE.
  always_comb begin
    state_d      = state_q;
    clrIdx_d     = clrIdx_q;
    latCnt_d     = latCnt_q;
    pendRdata_d  = pendRdata_q;
    pendErr_d    = pendErr_q;
    rspValid_d   = 1'b0;
    rspRdata_d   = 32'h0;
    rspErr_d     = 1'b0;
    traceValid_d = 1'b0;
    tracePc_d    = tracePc_q;
    traceAddr_d  = traceAddr_q;
    traceData_d  = traceData_q;
    memWe        = 1'b0;
    memWIdx      = clrIdx_q;
    memWData     = 32'h0;

    case (state_q)
      CLEAR: begin
        memWe = 1'b1;
        if (clrIdx_q == IDXW'(DEPTH - 1)) begin
          clrIdx_d = '0;
          state_d  = IDLE;
        end else begin
          clrIdx_d = clrIdx_q + 1'b1;
        end
      end

      IDLE: begin
        if (accept) begin
          if (bus.req_we && !reqErr) begin
            memWe        = 1'b1;
            memWIdx      = memIdx;
            memWData     = mergedWord;
            traceValid_d = 1'b1;
            tracePc_d    = bus.req_pc;
            traceAddr_d  = {bus.req_addr[31:2], 2'b00};
            traceData_d  = mergedWord;
          end
          // With LATENCY=1 the response goes out straight from the acceptance
          // edge; otherwise it waits in the pending registers through BUSY.
          if (LATENCY == 1) begin
            rspValid_d = 1'b1;
            rspRdata_d = loadResult;
            rspErr_d   = reqErr;
          end else begin
            state_d     = BUSY;
            latCnt_d    = 2'(LATENCY - 2);
            pendRdata_d = loadResult;
            pendErr_d   = reqErr;
          end
        end
      end

      BUSY: begin
        if (latCnt_q == 2'd0) begin
          state_d    = IDLE;
          rspValid_d = 1'b1;
          rspRdata_d = pendRdata_q;
          rspErr_d   = pendErr_q;
        end else begin
          latCnt_d = latCnt_q - 1'b1;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // Control and response registers; reset drops any in-flight response and
  // restarts the clear sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clrIdx_q     <= '0;
      latCnt_q     <= 2'd0;
      pendRdata_q  <= 32'h0;
      pendErr_q    <= 1'b0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= 32'h0;
      rspErr_q     <= 1'b0;
      traceValid_q <= 1'b0;
      tracePc_q    <= 32'h0;
      traceAddr_q  <= 32'h0;
      traceData_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      clrIdx_q     <= clrIdx_d;
      latCnt_q     <= latCnt_d;
      pendRdata_q  <= pendRdata_d;
      pendErr_q    <= pendErr_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      traceValid_q <= traceValid_d;
      tracePc_q    <= tracePc_d;
      traceAddr_q  <= traceAddr_d;
      traceData_q  <= traceData_d;
    end
  end

  // Storage array: no reset of its own, the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem_q[memWIdx] <= memWData;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.init_busy   = (state_q == CLEAR);
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_rdata   = rspRdata_q;
  assign bus.rsp_err     = rspErr_q;
  assign bus.trace_valid = traceValid_q;
  assign bus.trace_pc    = tracePc_q;
  assign bus.trace_addr  = traceAddr_q;
  assign bus.trace_data  = traceData_q;

endmodule

// File: tb/tb_byte_dm.sv
// -----------------------------------------------------------------------------
// tb_byte_dm
// Directed self-checking bench for byte_dm. Two instances share one clock:
//   dut1 : DEPTH=16, LATENCY=1, BASE_ADDR=0
//   dut3 : DEPTH=16, LATENCY=3, BASE_ADDR=0x100
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_byte_dm;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset1;
  logic reset3;

  int cmpCnt = 0;
  int errCnt = 0;

  byte_dm_if bus1();
  byte_dm_if bus3();

  byte_dm #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1.slave)
  );

  byte_dm #(.DEPTH(16), .LATENCY(3), .BASE_ADDR(32'h0000_0100)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (bus3.slave)
  );

  always #5 clk = ~clk;

  // Store trace log for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (bus1.trace_valid) begin
      $display("@%08h: *%08h <= %08h", bus1.trace_pc, bus1.trace_addr, bus1.trace_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCnt++;
    assert (observed === expected)
    else begin
      errCnt++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Drive one request into dut1 and advance to the next falling edge, where
  // its LATENCY=1 response is visible.
  task automatic applyStimulus(input logic we, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] pc);
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_op    = op;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    bus1.req_pc    = pc;
    @(negedge clk);
  endtask

  task automatic checkRsp1(input string tag, input logic [31:0] expData,
                           input logic expErr);
    checkOutput({tag, "_valid"}, {31'b0, bus1.rsp_valid}, 32'd1);
    checkOutput({tag, "_rdata"}, bus1.rsp_rdata, expData);
    checkOutput({tag, "_err"},   {31'b0, bus1.rsp_err}, {31'b0, expErr});
  endtask

  task automatic drive3(input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_op    = op;
    bus3.req_addr  = addr;
    bus3.req_wdata = wdata;
    bus3.req_pc    = 32'h0000_3000;
  endtask

  // Issue a dut3 request and wait (bounded) for its response pulse.
  task automatic transact3(input string tag, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expData, input logic expErr);
    logic got;
    got = 1'b0;
    drive3(we, op, addr, wdata);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus3.req_valid = 1'b0;
      if (bus3.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_seen"},  {31'b0, got}, 32'd1);
    checkOutput({tag, "_rdata"}, bus3.rsp_rdata, expData);
    checkOutput({tag, "_err"},   {31'b0, bus3.rsp_err}, {31'b0, expErr});
  endtask

  // Count falling edges with init_busy high on dut1, bounded.
  task automatic countClear1(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus1.init_busy) break;
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   busyCycles;
    logic sawRsp;

    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_op = OP_W;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_pc = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_op = OP_W;
    bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_pc = '0;
    reset1 = 1'b1;
    reset3 = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    checkOutput("rst_init_busy", {31'b0, bus1.init_busy}, 32'd1);
    checkOutput("rst_req_ready", {31'b0, bus1.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, bus1.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", bus1.rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err",   {31'b0, bus1.rsp_err}, 32'd0);
    reset1 = 1'b0;
    reset3 = 1'b0;

    // ---- clear lasts exactly DEPTH cycles ----
    countClear1(busyCycles);
    checkOutput("clear_cycles", busyCycles, 32'd16);
    checkOutput("idle_ready",   {31'b0, bus1.req_ready}, 32'd1);

    // ---- LATENCY=1 back-to-back traffic ----
    applyStimulus(1'b0, OP_W, 32'h0, 32'h0, 32'h0000_0100);
    checkRsp1("lw0", 32'h0, 1'b0);

    applyStimulus(1'b1, OP_W, 32'h8, 32'h1122_3344, 32'h0000_0200);
    checkRsp1("sw8", 32'h0, 1'b0);
    checkOutput("sw8_trace_v",    {31'b0, bus1.trace_valid}, 32'd1);
    checkOutput("sw8_trace_addr", bus1.trace_addr, 32'h0000_0008);
    checkOutput("sw8_trace_data", bus1.trace_data, 32'h1122_3344);
    checkOutput("sw8_trace_pc",   bus1.trace_pc,   32'h0000_0200);

    applyStimulus(1'b1, OP_BU, 32'h9, 32'h0000_00AA, 32'h0000_0204);
    checkRsp1("sb9", 32'h0, 1'b0);
    checkOutput("sb9_trace_data", bus1.trace_data, 32'h1122_AA44);

    applyStimulus(1'b0, OP_W, 32'h8, 32'h0, 32'h0000_0208);
    checkRsp1("lw8_merged", 32'h1122_AA44, 1'b0);
    checkOutput("lw8_no_trace", {31'b0, bus1.trace_valid}, 32'd0);

    // ---- load extension on 0x80FF7F01 ----
    applyStimulus(1'b1, OP_W, 32'h8, 32'h80FF_7F01, 32'h0000_0300);
    checkRsp1("sw8b", 32'h0, 1'b0);
    applyStimulus(1'b0, OP_BS, 32'hA, 32'h0, 32'h0000_0304);
    checkRsp1("lb_a", 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, OP_BU, 32'hB, 32'h0, 32'h0000_0308);
    checkRsp1("lbu_b", 32'h0000_0080, 1'b0);
    applyStimulus(1'b0, OP_HS, 32'h8, 32'h0, 32'h0000_030C);
    checkRsp1("lh_8", 32'h0000_7F01, 1'b0);
    applyStimulus(1'b0, OP_HU, 32'hA, 32'h0, 32'h0000_0310);
    checkRsp1("lhu_a", 32'h0000_80FF, 1'b0);
    applyStimulus(1'b0, OP_HS, 32'hA, 32'h0, 32'h0000_0314);
    checkRsp1("lh_a", 32'hFFFF_80FF, 1'b0);
    applyStimulus(1'b0, OP_BS, 32'h8, 32'h0, 32'h0000_0318);
    checkRsp1("lb_8", 32'h0000_0001, 1'b0);

    // ---- errors: misaligned and out of range ----
    applyStimulus(1'b1, OP_HU, 32'h3, 32'h0000_BEEF, 32'h0000_0400);
    checkRsp1("sh3_err", 32'h0, 1'b1);
    checkOutput("sh3_no_trace", {31'b0, bus1.trace_valid}, 32'd0);
    applyStimulus(1'b0, OP_W, 32'h2, 32'h0, 32'h0000_0404);
    checkRsp1("lw2_err", 32'h0, 1'b1);
    applyStimulus(1'b0, OP_W, 32'h8, 32'h0, 32'h0000_0408);
    checkRsp1("lw8_unchanged", 32'h80FF_7F01, 1'b0);
    applyStimulus(1'b0, OP_W, 32'h40, 32'h0, 32'h0000_040C);
    checkRsp1("lw40_err", 32'h0, 1'b1);
    applyStimulus(1'b1, OP_W, 32'h40, 32'h1234_5678, 32'h0000_0410);
    checkRsp1("sw40_err", 32'h0, 1'b1);
    checkOutput("sw40_no_trace", {31'b0, bus1.trace_valid}, 32'd0);

    // ---- last word boundary ----
    applyStimulus(1'b1, OP_W, 32'h3C, 32'hDEAD_BEEF, 32'h0000_0500);
    checkRsp1("sw3c", 32'h0, 1'b0);
    applyStimulus(1'b0, OP_W, 32'h3C, 32'h0, 32'h0000_0504);
    checkRsp1("lw3c", 32'hDEAD_BEEF, 1'b0);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_no_rsp", {31'b0, bus1.rsp_valid}, 32'd0);

    // ---- LATENCY=3 timing ----
    transact3("sw3_104", 1'b1, OP_W, 32'h104, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("l3_ready_pre", {31'b0, bus3.req_ready}, 32'd1);
    drive3(1'b0, OP_W, 32'h104, 32'h0);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    checkOutput("l3_c1_ready", {31'b0, bus3.req_ready}, 32'd0);
    checkOutput("l3_c1_valid", {31'b0, bus3.rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("l3_c2_ready", {31'b0, bus3.req_ready}, 32'd0);
    checkOutput("l3_c2_valid", {31'b0, bus3.rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("l3_c3_valid", {31'b0, bus3.rsp_valid}, 32'd1);
    checkOutput("l3_c3_ready", {31'b0, bus3.req_ready}, 32'd1);
    checkOutput("l3_c3_rdata", bus3.rsp_rdata, 32'h1234_5678);
    @(negedge clk);
    checkOutput("l3_c4_valid", {31'b0, bus3.rsp_valid}, 32'd0);

    transact3("l3_below_base", 1'b0, OP_W, 32'hFC, 32'h0, 32'h0, 1'b1);
    @(negedge clk);

    // ---- reset one cycle after acceptance drops the response ----
    drive3(1'b0, OP_W, 32'h104, 32'h0);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    checkOutput("l3_rst_ready", {31'b0, bus3.req_ready}, 32'd0);
    sawRsp = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus3.init_busy) break;
      busyCycles++;
      sawRsp = sawRsp | bus3.rsp_valid;
      @(negedge clk);
    end
    checkOutput("l3_rst_no_rsp", {31'b0, sawRsp}, 32'd0);
    checkOutput("l3_rst_clear_cycles", busyCycles, 32'd16);
    transact3("l3_after_clear", 1'b0, OP_W, 32'h104, 32'h0, 32'h0, 1'b0);

    // ---- reset reasserted mid-clear restarts the sweep ----
    reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    repeat (5) @(negedge clk);
    reset1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0;
    countClear1(busyCycles);
    checkOutput("midclear_cycles", busyCycles, 32'd16);
    applyStimulus(1'b0, OP_W, 32'h3C, 32'h0, 32'h0000_0600);
    checkRsp1("lw3c_cleared", 32'h0, 1'b0);
    applyStimulus(1'b0, OP_W, 32'h8, 32'h0, 32'h0000_0604);
    checkRsp1("lw8_cleared", 32'h0, 1'b0);
    bus1.req_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
